// File: rtl/test_status_reporter_pkg.sv
// Shared types and constants for the test status reporter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: reporter FSM state enum, tohost exit-flag bit position, watchdog exit code fill.
package test_status_pkg;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    DRAIN     = 2'd1,
    DONE_PASS = 2'd2,
    DONE_FAIL = 2'd3
  } state_e;

  // Bit of the tohost write data that flags "exit"; the remaining bits are the code.
  localparam int EXIT_BIT = 0;

  // Exit code reported when the watchdog fires; wide enough for any DATA_W and
  // truncated at the point of use.
  localparam logic [255:0] WATCHDOG_EXIT_CODE = '1;

endpackage

// File: rtl/test_status_reporter_if.sv
// Single-beat write request / write acknowledge bus into the test status reporter.
// Latency: n/a (wires only).
// Backpressure: req_valid/req_ready on the request, resp_valid/resp_ready on the acknowledge.
// Ports: master = DUT-side debug/tohost path, slave = reporter.
interface test_status_reporter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) ();

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic              resp_valid;
  logic              resp_ready;

  modport master (
    output req_valid, req_addr, req_data, resp_ready,
    input  req_ready, resp_valid
  );

  modport slave (
    input  req_valid, req_addr, req_data, resp_ready,
    output req_ready, resp_valid
  );

endinterface

// File: rtl/status_ack_buffer.sv
// Single-entry request accept / response hold register pair.
// Latency: resp_valid rises the cycle after accept; acc_vld is combinational with the accepting cycle.
// Backpressure: one write outstanding; req_ready is low while the acknowledge is held.
// Ports: clock, reset (sync, active-low), bus (slave modport), acc_vld (request accepted this cycle).
module status_ack_buffer (
  input  logic                   clock,
  input  logic                   reset,
  test_status_reporter_if.slave  bus,
  output logic                   acc_vld
);

  logic resp_valid_q;
  logic resp_valid_d;

  always_comb begin
    acc_vld      = bus.req_valid & ~resp_valid_q;
    resp_valid_d = resp_valid_q;
    if (resp_valid_q && bus.resp_ready) begin
      resp_valid_d = 1'b0;
    end
    // Accept only happens while no ack is held, so this never collides with the clear above.
    if (acc_vld) begin
      resp_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      resp_valid_q <= 1'b0;
    end else begin
      resp_valid_q <= resp_valid_d;
    end
  end

  assign bus.req_ready  = ~resp_valid_q;
  assign bus.resp_valid = resp_valid_q;

endmodule

// File: rtl/test_status_reporter.sv
// Harness test completion reporter: decodes tohost exit writes, drains, then holds sticky pass/fail.
// Latency: success/failure first high DRAIN_CYCLES+1 cycles after the accepting edge; ack 1 cycle after accept.
// Backpressure: one outstanding write; a held acknowledge blocks further requests.
// Ports: clock, reset (sync, active-low), bus (slave modport of test_status_reporter_if),
//        success, failure, exit_code (req_data[DATA_W-1:1] of the first exit), cycle_count (saturating).
// Optional: define TEST_STATUS_WATCHDOG_EN to add a RUN-state watchdog (parameter WATCHDOG_CYCLES).
module test_status_reporter
  import test_status_pkg::*;
#(
  parameter int                ADDR_W          = 32,
  parameter int                DATA_W          = 64,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR     = ADDR_W'(32'h8000_1000),
  parameter int                DRAIN_CYCLES    = 16
`ifdef TEST_STATUS_WATCHDOG_EN
  ,
  parameter longint            WATCHDOG_CYCLES = 1_000_000
`endif
) (
  input  logic                  clock,
  input  logic                  reset,
  test_status_reporter_if.slave bus,
  output logic                  success,
  output logic                  failure,
  output logic [DATA_W-2:0]     exit_code,
  output logic [63:0]           cycle_count
);

  localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  drain_q, drain_d;
  logic [DATA_W-2:0] exit_code_q, exit_code_d;
  logic [63:0]       cycle_count_q, cycle_count_d;
  logic              success_q, success_d;
  logic              failure_q, failure_d;
  logic              acc_vld;
  logic              is_exit;

  status_ack_buffer u_ack (
    .clock   (clock),
    .reset   (reset),
    .bus     (bus),
    .acc_vld (acc_vld)
  );

  always_comb begin
    state_d       = state_q;
    drain_d       = drain_q;
    exit_code_d   = exit_code_q;
    cycle_count_d = (&cycle_count_q) ? cycle_count_q : cycle_count_q + 64'd1;
    is_exit       = acc_vld && (bus.req_addr == TOHOST_ADDR) && bus.req_data[EXIT_BIT];

    case (state_q)
      RUN: begin
        if (is_exit) begin
          exit_code_d = bus.req_data[DATA_W-1:1];
          drain_d     = DRAIN_LOAD;
          state_d     = DRAIN;
        end
`ifdef TEST_STATUS_WATCHDOG_EN
        // Compare against the post-increment count so failure shows one cycle after the hit.
        else if (cycle_count_d == 64'(WATCHDOG_CYCLES)) begin
          exit_code_d = WATCHDOG_EXIT_CODE[DATA_W-2:0];
          state_d     = DONE_FAIL;
        end
`endif
      end
      DRAIN: begin
        if (drain_q == '0) begin
          state_d = (exit_code_q == '0) ? DONE_PASS : DONE_FAIL;
        end else begin
          drain_d = drain_q - 1'b1;
        end
      end
      default: begin
        // DONE_PASS / DONE_FAIL hold until reset; later exits are acked and ignored.
      end
    endcase

    // Registered off the current state, adding the extra cycle after DONE is entered.
    success_d = (state_q == DONE_PASS);
    failure_d = (state_q == DONE_FAIL);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q       <= RUN;
      drain_q       <= '0;
      exit_code_q   <= '0;
      cycle_count_q <= '0;
      success_q     <= 1'b0;
      failure_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      drain_q       <= drain_d;
      exit_code_q   <= exit_code_d;
      cycle_count_q <= cycle_count_d;
      success_q     <= success_d;
      failure_q     <= failure_d;
    end
  end

  assign success     = success_q;
  assign failure     = failure_q;
  assign exit_code   = exit_code_q;
  assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_test_status_reporter.sv
// Self-checking bench for test_status_reporter: directed plan sequences plus randomized traffic
// compared every cycle against a time-based reference model.
module tb_test_status_reporter;

  localparam logic [31:0] TOHOST = 32'h8000_1000;
  localparam logic [31:0] OTHER  = 32'h8000_2000;
  localparam int          DRAIN  = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        success;
  logic        failure;
  logic [62:0] exit_code;
  logic [63:0] cycle_count;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: tracks edge index since reset release and the edge of the first exit.
  int          m_k    = 0;
  bit          m_rv   = 1'b0;
  bit          m_seen = 1'b0;
  int          m_edge = 0;
  logic [62:0] m_code = '0;

  test_status_reporter_if #(.ADDR_W(32), .DATA_W(64)) bus ();

  test_status_reporter dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus),
    .success     (success),
    .failure     (failure),
    .exit_code   (exit_code),
    .cycle_count (cycle_count)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (edge %0d)", tag, obs, exp, m_k);
    end
  endtask

  // Advance the model by one rising edge using the inputs currently driven.
  task automatic model_edge();
    bit acc;
    if (!reset) begin
      m_k = 0; m_rv = 0; m_seen = 0; m_edge = 0; m_code = '0;
    end else begin
      acc = bus.req_valid && !m_rv;
      if (m_rv && bus.resp_ready) m_rv = 0;
      if (acc) m_rv = 1;
      m_k++;
      if (acc && !m_seen && bus.req_addr == TOHOST && bus.req_data[0]) begin
        m_seen = 1;
        m_edge = m_k;
        m_code = bus.req_data[63:1];
      end
    end
  endtask

  task automatic check_all();
    bit done;
    done = m_seen && (m_k >= m_edge + DRAIN + 1);
    check_eq("req_ready",   64'(bus.req_ready),  64'(!m_rv));
    check_eq("resp_valid",  64'(bus.resp_valid), 64'(m_rv));
    check_eq("success",     64'(success),        64'(done && m_code == '0));
    check_eq("failure",     64'(failure),        64'(done && m_code != '0));
    check_eq("exit_code",   64'(exit_code),      64'(m_seen ? m_code : 63'd0));
    check_eq("cycle_count", cycle_count,         64'(m_k));
  endtask

  // Called at a negedge: drive inputs, take one rising edge, check at the following negedge.
  task automatic tick(input logic rn, input logic v, input logic [31:0] a,
                      input logic [63:0] d, input logic rr);
    reset          = rn;
    bus.req_valid  = v;
    bus.req_addr   = a;
    bus.req_data   = d;
    bus.resp_ready = rr;
    @(posedge clock);
    model_edge();
    @(negedge clock);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b1, 1'b0, 32'h0, 64'h0, 1'b1);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 32'h0, 64'h0, 1'b1);
  endtask

  initial begin
    logic [63:0] d;
    logic [31:0] a;

    // Reset values.
    do_reset(3);
    check_eq("rst_success", 64'(success), 64'd0);
    check_eq("rst_count",   cycle_count,  64'd0);

    // Pass: exit code 0.
    tick(1'b1, 1'b1, TOHOST, 64'h1, 1'b1);
    idle(DRAIN + 3);
    check_eq("pass_success", 64'(success),   64'd1);
    check_eq("pass_failure", 64'(failure),   64'd0);
    check_eq("pass_code",    64'(exit_code), 64'd0);

    // Fail: exit code 3.
    do_reset(2);
    tick(1'b1, 1'b1, TOHOST, 64'h7, 1'b1);
    idle(DRAIN + 3);
    check_eq("fail_failure", 64'(failure),   64'd1);
    check_eq("fail_success", 64'(success),   64'd0);
    check_eq("fail_code",    64'(exit_code), 64'd3);

    // Non-exit writes: other address, tohost with bit0 clear.
    do_reset(2);
    tick(1'b1, 1'b1, OTHER, 64'h1, 1'b1);
    idle(1);
    tick(1'b1, 1'b1, TOHOST, 64'h4, 1'b1);
    idle(DRAIN + 3);
    check_eq("nonexit_success", 64'(success), 64'd0);
    check_eq("nonexit_failure", 64'(failure), 64'd0);

    // Backpressure: ack held while resp_ready low; second request waits.
    do_reset(2);
    tick(1'b1, 1'b1, OTHER, 64'h5, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 1'b1, OTHER, 64'h6, 1'b0);
      check_eq("bp_req_ready",  64'(bus.req_ready),  64'd0);
      check_eq("bp_resp_valid", 64'(bus.resp_valid), 64'd1);
    end
    tick(1'b1, 1'b1, OTHER, 64'h6, 1'b1);
    check_eq("bp_released", 64'(bus.resp_valid), 64'd0);
    tick(1'b1, 1'b1, OTHER, 64'h6, 1'b1);
    check_eq("bp_second_acc", 64'(bus.resp_valid), 64'd1);
    idle(2);

    // First exit wins: a failing exit during drain is ignored.
    do_reset(2);
    tick(1'b1, 1'b1, TOHOST, 64'h1, 1'b1);
    idle(3);
    tick(1'b1, 1'b1, TOHOST, 64'h9, 1'b1);
    idle(DRAIN + 2);
    check_eq("first_wins_success", 64'(success),   64'd1);
    check_eq("first_wins_code",    64'(exit_code), 64'd0);

    // Reset in the middle of the drain window aborts everything.
    do_reset(2);
    tick(1'b1, 1'b1, TOHOST, 64'h7, 1'b1);
    idle(4);
    do_reset(1);
    check_eq("midrst_count", cycle_count, 64'd0);
    check_eq("midrst_code",  64'(exit_code), 64'd0);
    idle(DRAIN + 4);
    check_eq("midrst_failure", 64'(failure), 64'd0);

    // Randomized traffic.
    for (int seg = 0; seg < 12; seg++) begin
      do_reset(1 + int'($urandom_range(0, 2)));
      for (int c = 0; c < 80; c++) begin
        a = ($urandom_range(0, 2) == 0) ? 32'($urandom) : TOHOST;
        case ($urandom_range(0, 3))
          0:       d = {32'($urandom), 32'($urandom)};
          1:       d = 64'h1;
          2:       d = ($urandom_range(0, 1) == 0) ? 64'h0 : 64'h4;
          default: d = (64'($urandom_range(0, 3)) << 1) | 64'h1;
        endcase
        tick(1'b1, ($urandom_range(0, 2) != 0), a, d, ($urandom_range(0, 3) != 0));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/test_status_reporter.md
Name: test_status_reporter

Overview:
Harness-side test completion reporter; it is the source of the `success` signal that the top-level test driver samples each cycle.
- Accepts single-beat writes from the DUT's memory-mapped debug/tohost path via a valid/ready request and valid/ready response pair.
- Decodes "exit" writes to a fixed tohost address and waits a flush window so pending printfs drain.
- Then holds a sticky pass or fail indication with the exit code.

Parameters:
ADDR_W, 32, request address width
DATA_W, 64, request data width (min 2)
TOHOST_ADDR, 32'h8000_1000, address decoded as tohost
DRAIN_CYCLES, 16, cycles between exit decode and success/failure assertion (min 1)

Ports:
clock  input  1  clock
reset  input  1  reset, synchronous, active-low
req_valid  input  1  write request valid
req_ready  output  1  request accept
req_addr  input  ADDR_W  write address
req_data  input  DATA_W  write data
resp_valid  output  1  write acknowledge valid
resp_ready  input  1  acknowledge accept
success  output  1  sticky pass (exit code 0)
failure  output  1  sticky fail (nonzero code or watchdog)
exit_code  output  DATA_W-1  latched req_data[DATA_W-1:1]
cycle_count  output  64  cycles since reset release, saturating

Behaviour:
- Reset (reset==0 at a posedge) values:
  - FSM = RUN; all outputs 0.
  - cycle_count = 0; drain counter = 0.
  - Reset mid-drain or in DONE aborts everything.
- cycle_count increments every cycle out of reset and saturates at all-ones.
- Handshake:
  - req_ready = !resp_valid (one outstanding write).
  - Accept = req_valid & req_ready.
  - resp_valid rises the cycle after accept and holds until resp_valid & resp_ready; it then falls the next cycle.
  - With resp_ready tied 1, max throughput is one write per 2 cycles.
  - Every accepted write is acknowledged, whatever its address or state.
- Decode on accept, only in state RUN:
  - Exit: req_addr==TOHOST_ADDR and req_data[0]==1.
    - Latch exit_code = req_data[DATA_W-1:1].
    - Load drain counter = DRAIN_CYCLES-1 and go to DRAIN.
  - Non-exit: tohost with req_data[0]==0, or any other address. Acked, no state effect.
- Exit decode in DRAIN/DONE_PASS/DONE_FAIL is ignored. First exit wins; exit_code is never overwritten.
- FSM:
  - RUN -> DRAIN on exit decode.
  - DRAIN decrements the counter each cycle. On counter==0:
    - exit_code==0 -> DONE_PASS;
    - otherwise -> DONE_FAIL.
  - DONE_PASS and DONE_FAIL are terminal until reset.
- Outputs are registered:
  - success = (state==DONE_PASS); failure = (state==DONE_FAIL).
  - Never both high.
  - First high exactly DRAIN_CYCLES+1 cycles after the accepting edge.

Optional Feature:
TEST_STATUS_WATCHDOG_EN:
- Defined:
  - Adds parameter WATCHDOG_CYCLES (default 1_000_000).
  - In RUN, if cycle_count reaches WATCHDOG_CYCLES, go directly to DONE_FAIL with exit_code = all-ones; failure rises the next cycle.
  - An exit accept in the same cycle as the watchdog hit takes precedence.
  - DRAIN is not subject to the watchdog.
- Undefined: no timeout logic; the driver's max-cycles check is the only timeout.

Decomposition:
- Shared package test_status_pkg holds:
  - state enum {RUN, DRAIN, DONE_PASS, DONE_FAIL};
  - EXIT_BIT = 0 constant;
  - watchdog exit_code constant (all-ones).
- One natural sub-module: status_ack_buffer, the single-entry request-accept/response-hold register pair.
- FSM, drain counter and cycle counter stay in the top.

Test Plan:
- Reset released; write tohost data 64'h1, resp_ready=1 -> resp_valid 1 cycle after accept; success=1 exactly 17 cycles after accept; failure=0; exit_code=0.
- Write tohost data 64'h7 -> failure=1 after 17 cycles; exit_code=3; success stays 0.
- Writes to 32'h8000_2000 and to tohost with data 64'h4 -> both acked; FSM stays RUN; no outputs change.
- resp_ready held 0 for 5 cycles after accept -> resp_valid held, req_ready=0, a second req_valid is not accepted; after resp_ready=1 the second write is accepted the cycle after resp_valid falls.
- Exit 64'h1, then during DRAIN exit 64'h9 -> second write acked, ignored; success=1, exit_code=0.
- Assert reset (low) during DRAIN at cycle 5 of the window -> outputs 0, state RUN, cycle_count=0. With TEST_STATUS_WATCHDOG_EN and WATCHDOG_CYCLES=100, no writes -> failure=1 at cycle 101, exit_code all-ones.
